// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch/load-store memory bus arbiter.
package cpu_pkg;
   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;
   localparam int STRB_W     = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      INSTR      = 2'd1,
      INSTR_KILL = 2'd2,
      DATA       = 2'd3
   } arb_state_t;
endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Fetch, load/store and unified memory bus signals; slave is the arbiter's view,
// master is the pipeline/memory side that drives requests and acks.
interface imem_dmem_arbiter_if #(
   parameter int ADDR_W = cpu_pkg::BUS_ADDR_W,
   parameter int DATA_W = cpu_pkg::BUS_DATA_W
) ();
   import cpu_pkg::*;

   logic              instr_req;
   logic [ADDR_W-1:0] instr_addr;
   logic              flush;
   logic              instr_valid;
   logic [DATA_W-1:0] instr_rdata;
   logic              data_req;
   logic              data_we;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic [STRB_W-1:0] data_strb;
   logic              data_valid;
   logic [DATA_W-1:0] data_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_strb;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              bus_err;

   modport slave (
      input  instr_req, instr_addr, flush, data_req, data_we, data_addr, data_wdata, data_strb,
      input  mem_ack, mem_rdata,
      output instr_valid, instr_rdata, data_valid, data_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_strb, bus_err
   );

   modport master (
      output instr_req, instr_addr, flush, data_req, data_we, data_addr, data_wdata, data_strb,
      output mem_ack, mem_rdata,
      input  instr_valid, instr_rdata, data_valid, data_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_strb, bus_err
   );
endinterface

// File: rtl/arb_watchdog.sv
// Ack-timeout counter: counts enabled cycles since the last clear and flags the
// cycle in which the TIMEOUT-th enabled cycle ends without an ack.
module arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   logic [7:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign expire_o = en_i && (cnt_q == 8'(TIMEOUT - 1));
endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares the unified memory bus between fetch and load/store, one transaction at a time.
// Request-to-valid is at least 2 cycles; requesters stall by holding req until their valid.
module imem_dmem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W          = BUS_ADDR_W,
   parameter int DATA_W          = BUS_DATA_W,
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT         = 255
) (
   input logic               clk,
   input logic               rst,
   imem_dmem_arbiter_if.slave bus
);
   localparam int SW = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   arb_state_t        state_q;
   logic [SW-1:0]     streak_q;
   logic              mem_req_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [STRB_W-1:0] mem_strb_q;
   logic              instr_valid_q, data_valid_q, bus_err_q;
   logic [DATA_W-1:0] instr_rdata_q, data_rdata_q;
   logic              grant_data, grant_instr, expire;

   always_comb begin
      grant_data  = 1'b0;
      grant_instr = 1'b0;
      if (state_q == IDLE) begin
         grant_data  = bus.data_req && !(bus.instr_req && streak_q == STREAK_MAX);
         grant_instr = !grant_data && bus.instr_req && !bus.flush;
      end
   end

   arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (grant_data || grant_instr),
      .en_i     (mem_req_q),
      .expire_o (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         streak_q      <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_strb_q    <= '0;
         instr_valid_q <= 1'b0;
         data_valid_q  <= 1'b0;
         bus_err_q     <= 1'b0;
         instr_rdata_q <= DATA_W'(NOP_INSTR);
         data_rdata_q  <= '0;
      end else begin
         instr_valid_q <= 1'b0;
         data_valid_q  <= 1'b0;
         bus_err_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_data) begin
                  state_q     <= DATA;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= bus.data_we;
                  mem_addr_q  <= bus.data_addr;
                  mem_wdata_q <= bus.data_wdata;
                  mem_strb_q  <= bus.data_strb;
                  // a data grant with fetch waiting implies streak < max, so no overflow
                  streak_q    <= bus.instr_req ? streak_q + 1'b1 : '0;
               end else if (grant_instr) begin
                  state_q     <= INSTR;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bus.instr_addr;
                  mem_wdata_q <= '0;
                  mem_strb_q  <= '0;
                  streak_q    <= '0;
               end
            end
            default: begin
               if (bus.mem_ack || expire) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
                  bus_err_q <= !bus.mem_ack;
                  if (state_q == DATA) begin
                     data_valid_q <= 1'b1;
                     data_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
                  end else if (state_q == INSTR && !bus.flush) begin
                     instr_valid_q <= 1'b1;
                     instr_rdata_q <= bus.mem_ack ? bus.mem_rdata : DATA_W'(NOP_INSTR);
                  end
               end else if (state_q == INSTR && bus.flush) begin
                  state_q <= INSTR_KILL;
               end
            end
         endcase
      end
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.mem_strb    = mem_strb_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr_rdata = instr_rdata_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.data_rdata  = data_rdata_q;
   assign bus.bus_err     = bus_err_q;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model of the arbitration rules.
module tb_imem_dmem_arbiter;
   localparam int MAXS = 4;
   localparam int TMO  = 255;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   hi_cnt   = 0;

   imem_dmem_arbiter_if bus ();

   imem_dmem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAXS), .TIMEOUT(TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // reference model: who owns the bus (0 none, 1 fetch, 2 data) and the expected outputs
   int          m_owner  = 0;
   bit          m_killed = 1'b0;
   int          m_age    = 0;
   int          m_streak = 0;
   logic        e_req, e_we, e_ivld, e_dvld, e_err;
   logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
   logic [3:0]  e_strb;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit fetch_ok;
      e_ivld = 1'b0;
      e_dvld = 1'b0;
      e_err  = 1'b0;
      if (rst) begin
         m_owner = 0; m_age = 0; m_streak = 0; m_killed = 1'b0;
         e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0;
         e_irdata = NOP; e_drdata = '0;
         return;
      end
      if (m_owner == 0) begin
         if (bus.data_req && !(bus.instr_req && m_streak == MAXS)) begin
            m_owner = 2; m_age = 0;
            e_req = 1'b1; e_we = bus.data_we; e_addr = bus.data_addr;
            e_wdata = bus.data_wdata; e_strb = bus.data_strb;
            m_streak = bus.instr_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
         end else if (bus.instr_req && !bus.flush) begin
            m_owner = 1; m_age = 0; m_killed = 1'b0;
            e_req = 1'b1; e_we = 1'b0; e_addr = bus.instr_addr; e_strb = '0;
            m_streak = 0;
         end
      end else begin
         m_age++;
         fetch_ok = (m_owner == 1) && !m_killed && !bus.flush;
         if (bus.mem_ack || m_age == TMO) begin
            e_err = !bus.mem_ack;
            e_req = 1'b0;
            if (m_owner == 2) begin
               e_dvld = 1'b1;
               e_drdata = bus.mem_ack ? bus.mem_rdata : 32'h0;
            end else if (fetch_ok) begin
               e_ivld = 1'b1;
               e_irdata = bus.mem_ack ? bus.mem_rdata : NOP;
            end
            m_owner = 0;
         end else if (m_owner == 1 && bus.flush) begin
            m_killed = 1'b1;
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      if (bus.mem_req) hi_cnt++;
      chk("mem_req", 96'(bus.mem_req), 96'(e_req));
      chk("mem_ctl", 96'({bus.mem_we, bus.mem_strb, bus.mem_addr}), 96'({e_we, e_strb, e_addr}));
      if (e_req && m_owner == 2) chk("mem_wdata", 96'(bus.mem_wdata), 96'(e_wdata));
      chk("instr_valid", 96'(bus.instr_valid), 96'(e_ivld));
      chk("instr_rdata", 96'(bus.instr_rdata), 96'(e_irdata));
      chk("data_valid", 96'(bus.data_valid), 96'(e_dvld));
      chk("data_rdata", 96'(bus.data_rdata), 96'(e_drdata));
      chk("bus_err", 96'(bus.bus_err), 96'(e_err));
   endtask

   initial begin
      int g[$];
      logic prev;
      logic [31:0] save_ir;
      int dly;

      rst = 1'b1;
      bus.instr_req = 1'b0; bus.instr_addr = '0; bus.flush = 1'b0;
      bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0;
      bus.data_wdata = '0; bus.data_strb = '0;
      bus.mem_ack = 1'b0; bus.mem_rdata = '0;
      step();
      step();
      chk("rst_irdata", 96'(bus.instr_rdata), 96'(NOP));
      chk("rst_pulses", 96'({bus.mem_req, bus.instr_valid, bus.data_valid, bus.bus_err}), 96'(0));
      rst = 1'b0;

      // lone fetch, ack on the third mem_req cycle
      hi_cnt = 0;
      bus.instr_req = 1'b1; bus.instr_addr = 32'h0;
      step();
      chk("lone_we", 96'(bus.mem_we), 96'(0));
      step();
      step();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0050_0093;
      step();
      bus.mem_ack = 1'b0; bus.instr_req = 1'b0;
      chk("lone_hi", 96'(hi_cnt), 96'(3));
      chk("lone_ivld", 96'(bus.instr_valid), 96'(1));
      chk("lone_irdata", 96'(bus.instr_rdata), 96'(32'h0050_0093));
      step();

      // simultaneous store and fetch: store first, one idle cycle, then fetch
      bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 32'h100;
      bus.data_wdata = 32'hDEAD_BEEF; bus.data_strb = 4'b0011;
      bus.instr_req = 1'b1; bus.instr_addr = 32'h200;
      step();
      chk("sim_store", 96'({bus.mem_we, bus.mem_strb, bus.mem_addr, bus.mem_wdata}),
          96'({1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF}));
      step();
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0; bus.data_req = 1'b0;
      chk("sim_gap", 96'(bus.mem_req), 96'(0));
      step();
      chk("sim_fetch", 96'({bus.mem_req, bus.mem_we, bus.mem_strb, bus.mem_addr}),
          96'({1'b1, 1'b0, 4'b0000, 32'h200}));
      step();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_1111;
      step();
      bus.mem_ack = 1'b0; bus.instr_req = 1'b0;
      step();

      // starvation guard with zero-wait acks
      bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h300;
      bus.instr_req = 1'b1; bus.instr_addr = 32'h80;
      prev = 1'b0;
      for (int c = 0; c < 60 && g.size() < 10; c++) begin
         bus.mem_ack = e_req; bus.mem_rdata = $urandom;
         step();
         if (bus.mem_req && !prev) g.push_back((bus.mem_addr == 32'h300) ? 2 : 1);
         prev = bus.mem_req;
         if (e_ivld) bus.instr_addr = bus.instr_addr + 32'd4;
      end
      chk("starv_cnt", 96'(g.size()), 96'(10));
      for (int i = 0; i < 10 && i < g.size(); i++)
         chk("starv_seq", 96'(g[i]), 96'((i == 4 || i == 9) ? 1 : 2));
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0; bus.data_req = 1'b0; bus.instr_req = 1'b0;
      step();

      // flush while the fetch is in flight
      bus.instr_req = 1'b1; bus.instr_addr = 32'h20;
      step();
      save_ir = e_irdata;
      bus.flush = 1'b1; bus.instr_req = 1'b0;
      step();
      bus.flush = 1'b0;
      step();
      step();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
      step();
      bus.mem_ack = 1'b0;
      chk("flush_ivld", 96'(bus.instr_valid), 96'(0));
      chk("flush_irdata", 96'(bus.instr_rdata), 96'(save_ir));
      chk("flush_idle", 96'(bus.mem_req), 96'(0));
      bus.instr_req = 1'b1; bus.instr_addr = 32'h40;
      step();
      chk("flush_next_addr", 96'(bus.mem_addr), 96'(32'h40));
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
      step();
      bus.mem_ack = 1'b0; bus.instr_req = 1'b0;
      chk("flush_next_data", 96'({bus.instr_valid, bus.instr_rdata}), 96'({1'b1, 32'h1234_5678}));
      step();

      // ack timeout on a load, then a late ack
      hi_cnt = 0;
      bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h400;
      step();
      for (int c = 0; c < 300 && bus.mem_req; c++) step();
      chk("tmo_hi", 96'(hi_cnt), 96'(TMO));
      chk("tmo_pulse", 96'({bus.bus_err, bus.data_valid, bus.data_rdata}), 96'({1'b1, 1'b1, 32'h0}));
      bus.data_req = 1'b0;
      repeat (4) step();
      bus.mem_ack = 1'b1;
      step();
      bus.mem_ack = 1'b0;
      chk("late_ack", 96'({bus.data_valid, bus.bus_err}), 96'(0));
      step();

      // reset in the middle of a store; acks during and after reset are ignored
      bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 32'h500;
      bus.data_wdata = 32'hCAFE_F00D; bus.data_strb = 4'hF;
      step();
      step();
      rst = 1'b1;
      step();
      chk("mid_rst", 96'({bus.mem_req, bus.instr_valid, bus.data_valid, bus.bus_err, bus.instr_rdata}),
          96'({4'b0000, NOP}));
      bus.data_req = 1'b0; bus.mem_ack = 1'b1;
      step();
      rst = 1'b0;
      step();
      bus.mem_ack = 1'b0;
      chk("rst_ack_ign", 96'({bus.mem_req, bus.data_valid}), 96'(0));
      step();

      // random traffic
      dly = 0;
      for (int c = 0; c < 5000; c++) begin
         if (e_ivld) bus.instr_req = 1'b0;
         else if (!bus.instr_req && $urandom_range(3) == 0) begin
            bus.instr_req = 1'b1; bus.instr_addr = $urandom & 32'hFFFF_FFFC;
         end
         bus.flush = ($urandom_range(15) == 0);
         if (bus.flush && bus.instr_req) bus.instr_addr = $urandom & 32'hFFFF_FFFC;
         if (e_dvld) bus.data_req = 1'b0;
         else if (!bus.data_req && $urandom_range(2) == 0) begin
            bus.data_req = 1'b1; bus.data_we = 1'($urandom_range(1));
            bus.data_addr = $urandom; bus.data_wdata = $urandom;
            bus.data_strb = 4'($urandom_range(15));
         end
         if (e_req) begin
            if (m_age == 0) dly = ($urandom_range(59) == 0) ? 1000 : $urandom_range(3);
            bus.mem_ack = (m_age == dly);
         end else begin
            bus.mem_ack = ($urandom_range(49) == 0);
         end
         bus.mem_rdata = $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
